// File: rtl/ps2_scancode_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_tracker_if
// Description : Byte-in / key-state-out bundle between the PS/2 byte receiver
//               side (master) and the scancode tracker (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scancode_tracker_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;

    // Byte source: drives received bytes, observes key state.
    modport master (
        output rx_data,
        output rx_valid,
        input  key_down,
        input  last_change,
        input  key_valid
    );

    // Tracker: consumes bytes, publishes key state.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output key_down,
        output last_change,
        output key_valid
    );
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_tracker
// Description : Parses Set-2 make/break/E0/E1 byte sequences into a 512-entry
//               key-held vector indexed by {extended, scancode}, reporting each
//               completed make/break event with a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
    input  wire                    clk,
    input  wire                    rst,
    ps2_scancode_tracker_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value at which one more idle cycle means the sequence expires.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    state_t           state_q;
    logic [2:0]       skip_cnt_q;
    logic [CNT_W-1:0] to_cnt_q;
    logic [511:0]     key_down_q;
    logic [8:0]       last_change_q;
    logic             key_valid_q;

    logic [7:0]       w_byte;
    logic             w_err;

    assign w_byte = bus.rx_data;
    // Keyboard buffer overrun codes wipe the held-key picture.
    assign w_err  = (w_byte == 8'h00) || (w_byte == 8'hFF);

    // Sequence parser, key-state vector, event strobe and inter-byte timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            skip_cnt_q    <= 3'd0;
            to_cnt_q      <= '0;
            key_down_q    <= '0;
            last_change_q <= 9'h000;
            key_valid_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (bus.rx_valid) begin
                // A byte always restarts the idle window, even on the expiry cycle.
                to_cnt_q <= '0;
                if (w_err) begin
                    key_down_q <= '0;
                    state_q    <= ST_IDLE;
                    skip_cnt_q <= 3'd0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            case (w_byte)
                                8'hE0: state_q <= ST_EXT;
                                8'hF0: state_q <= ST_BRK;
                                8'hE1: begin
                                    state_q    <= ST_SKIP;
                                    skip_cnt_q <= 3'd7;
                                end
                                // Keyboard status/ack responses carry no key.
                                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC: begin
                                    state_q <= ST_IDLE;
                                end
                                default: begin
                                    key_down_q[{1'b0, w_byte}] <= 1'b1;
                                    last_change_q              <= {1'b0, w_byte};
                                    key_valid_q                <= 1'b1;
                                end
                            endcase
                        end
                        ST_EXT: begin
                            if (w_byte == 8'hF0) begin
                                state_q <= ST_EXT_BRK;
                            end else if (w_byte != 8'hE0) begin
                                key_down_q[{1'b1, w_byte}] <= 1'b1;
                                last_change_q              <= {1'b1, w_byte};
                                key_valid_q                <= 1'b1;
                                state_q                    <= ST_IDLE;
                            end
                        end
                        ST_BRK: begin
                            key_down_q[{1'b0, w_byte}] <= 1'b0;
                            last_change_q              <= {1'b0, w_byte};
                            key_valid_q                <= 1'b1;
                            state_q                    <= ST_IDLE;
                        end
                        ST_EXT_BRK: begin
                            key_down_q[{1'b1, w_byte}] <= 1'b0;
                            last_change_q              <= {1'b1, w_byte};
                            key_valid_q                <= 1'b1;
                            state_q                    <= ST_IDLE;
                        end
                        ST_SKIP: begin
                            // Pause key: swallow the remaining bytes silently.
                            if (skip_cnt_q == 3'd1) begin
                                state_q    <= ST_IDLE;
                                skip_cnt_q <= 3'd0;
                            end else begin
                                skip_cnt_q <= skip_cnt_q - 3'd1;
                            end
                        end
                        default: begin
                            state_q    <= ST_IDLE;
                            skip_cnt_q <= 3'd0;
                        end
                    endcase
                end
            end else if (state_q != ST_IDLE) begin
                if (to_cnt_q == TO_LAST) begin
                    // Stalled multi-byte sequence: abandon it, keep key state.
                    state_q    <= ST_IDLE;
                    skip_cnt_q <= 3'd0;
                    to_cnt_q   <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.key_down    = key_down_q;
    assign bus.last_change = last_change_q;
    assign bus.key_valid   = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_tracker
// Description : Self-checking bench for ps2_scancode_tracker: directed
//               sequences plus randomized byte streams against a reference
//               model of the make/break/extended/pause/timeout rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_tracker;

    localparam int T_TO = 20;

    logic clk;
    logic rst;

    ps2_scancode_tracker_if bus ();

    ps2_scancode_tracker #(
        .TIMEOUT_CYCLES(T_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: key picture plus the pending prefix of a sequence.
    logic [511:0] m_keys;
    logic [8:0]   m_last;
    logic         m_valid;
    bit           m_ext;
    bit           m_brk;
    int           m_skip;
    int           m_last_cyc;
    int           cyc = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_clear_ctx();
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
    endfunction

    function automatic void model_reset();
        m_keys  = '0;
        m_last  = 9'h000;
        m_valid = 1'b0;
        model_clear_ctx();
    endfunction

    function automatic void model_event(input bit e, input logic [7:0] b, input bit down);
        logic [8:0] idx;
        idx         = {e, b};
        m_keys[idx] = down;
        m_last      = idx;
        m_valid     = 1'b1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        m_valid = 1'b0;
        // A sequence whose previous byte is older than the timeout is dropped.
        if ((m_ext || m_brk || m_skip > 0) && (cyc - m_last_cyc > T_TO))
            model_clear_ctx();
        m_last_cyc = cyc;
        if (b == 8'h00 || b == 8'hFF) begin
            m_keys = '0;
            model_clear_ctx();
            return;
        end
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        if (m_brk) begin
            model_event(m_ext, b, 1'b0);
            model_clear_ctx();
            return;
        end
        if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) begin
                model_event(1'b1, b, 1'b1);
                model_clear_ctx();
            end
            return;
        end
        case (b)
            8'hE0: m_ext = 1'b1;
            8'hF0: m_brk = 1'b1;
            8'hE1: m_skip = 7;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC: ;
            default: model_event(1'b0, b, 1'b1);
        endcase
    endfunction

    task automatic compare_all();
        check("key_down",    bus.key_down,    m_keys);
        check("last_change", bus.last_change, m_last);
        check("key_valid",   bus.key_valid,   m_valid);
    endtask

    // One clock: compare against the model, then drive the next input.
    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        compare_all();
        rst          = 1'b0;
        bus.rx_valid = v;
        bus.rx_data  = b;
        if (v) model_byte(b);
        else   m_valid = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_all();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        cyc++;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[k]) step(1'b1, s[k]);
    endtask

    initial begin
        logic [511:0] kd;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_key_down", bus.key_down, '0);
        check("rst_last", bus.last_change, 9'h000);
        check("rst_valid", bus.key_valid, 1'b0);

        // Make then break of 1C.
        step(1'b1, 8'h1C);
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("make1C_bit", kd[9'h01C], 1'b1);
        check("make1C_valid", bus.key_valid, 1'b1);
        check("make1C_last", bus.last_change, 9'h01C);
        step(1'b0, 8'h00);
        check("make1C_pulse_end", bus.key_valid, 1'b0);
        send_seq('{8'hF0, 8'h1C});
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("brk1C_bit", kd[9'h01C], 1'b0);
        check("brk1C_valid", bus.key_valid, 1'b1);

        // Extended make/break of 75.
        send_seq('{8'hE0, 8'h75});
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("ext75_set", kd[9'h175], 1'b1);
        check("ext75_plain", kd[9'h075], 1'b0);
        check("ext75_last", bus.last_change, 9'h175);
        send_seq('{8'hE0, 8'hF0, 8'h75});
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("ext75_clr", kd[9'h175], 1'b0);
        check("ext75_last2", bus.last_change, 9'h175);

        // Shift held plus typematic repeats.
        send_seq('{8'h12, 8'h1C, 8'h1C, 8'h1C});
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("typematic_shift", kd[9'h012], 1'b1);
        check("typematic_1C", kd[9'h01C], 1'b1);

        // Pause sequence then 1C.
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
        step(1'b0, 8'h00);

        // Timeout: byte after the window is a plain make.
        send_seq('{8'hFF});
        step(1'b1, 8'hE0);
        repeat (T_TO + 1) step(1'b0, 8'h00);
        step(1'b1, 8'h6B);
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("to_plain_6B", kd[9'h06B], 1'b1);
        check("to_plain_16B", kd[9'h16B], 1'b0);

        // Byte arriving exactly on the expiry cycle keeps the extension.
        step(1'b1, 8'hE0);
        repeat (T_TO - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h6B);
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("to_edge_16B", kd[9'h16B], 1'b1);

        // Overrun clears everything, no pulse.
        send_seq('{8'h12, 8'h23, 8'hFF});
        step(1'b0, 8'h00);
        check("ovr_clear", bus.key_down, '0);
        check("ovr_no_pulse", bus.key_valid, 1'b0);

        // Reset after F0: next 1C is a make.
        step(1'b1, 8'hF0);
        do_reset();
        step(1'b1, 8'h1C);
        step(1'b0, 8'h00);
        kd = bus.key_down;
        check("rst_midseq_make", kd[9'h01C], 1'b1);

        // Randomized streams.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int p;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 30) begin
                step(1'b0, 8'h00);
            end else if (r < 33) begin
                int g;
                g = $urandom_range(T_TO - 2, T_TO + 1);
                step(1'b1, ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0);
                repeat (g) step(1'b0, 8'h00);
            end else begin
                p = $urandom_range(0, 99);
                if      (p < 12) b = 8'hE0;
                else if (p < 24) b = 8'hF0;
                else if (p < 27) b = 8'hE1;
                else if (p < 30) begin
                    case ($urandom_range(0, 4))
                        0:       b = 8'hAA;
                        1:       b = 8'hFA;
                        2:       b = 8'hEE;
                        3:       b = 8'hFE;
                        default: b = 8'hFC;
                    endcase
                end
                else if (p < 31) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                else if (p < 85) b = 8'($urandom_range(1, 16) * 5);
                else             b = 8'($urandom_range(0, 255));
                step(1'b1, b);
            end
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_scancode_tracker.md
# ps2_scancode_tracker

Converts the byte stream from the PS/2 byte receiver into per-key pressed state, and sits directly upstream of the keyboard consumers (caps/shift controllers, letter decoders). It parses Set-2 make, break, extended (E0) and pause (E1) sequences. It maintains a 512-bit `key_down` vector indexed by `{extended, scancode}`. On every completed make or break event it reports the key index on `last_change` and strobes `key_valid` for one cycle.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 500_000: idle cycles allowed between bytes of a multi-byte sequence before the parser abandons it (5 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received scancode byte, valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe, one per received byte.
- `key_down`  out  512  bit i=1 while key i is held; i = {ext bit, 8-bit code}, so the upper 256 entries are the E0 keys.
- `last_change`  out  9  index of the most recent make/break event.
- `key_valid`  out  1  one-cycle pulse marking a new event on `last_change`.

## Operation

- FSM states and byte handling:
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → SKIP with `skip_cnt`=7.
    - AA, FA, EE, FE, FC → ignored, stay IDLE.
    - Any other byte b → make event, index {0,b}.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay EXT.
    - Any other b → make event, index {1,b}, then IDLE.
  - BRK: any byte b → break event, index {0,b}, then IDLE.
  - EXT_BRK: any byte b → break event, index {1,b}, then IDLE.
  - SKIP:
    - Each byte decrements `skip_cnt`.
    - When the byte arrives with `skip_cnt`=1, go to IDLE.
    - The pause sequence E1 14 77 E1 F0 14 F0 77 produces no event.
- Make event on index i:
  - `key_down[i]`←1, `last_change`←i, `key_valid` pulse.
  - A repeat make (typematic) of an already-set bit still updates `last_change` and pulses `key_valid`; `key_down` is unchanged.
- Break event on index i:
  - `key_down[i]`←0, `last_change`←i, `key_valid` pulse.
  - A break of an already-clear key still pulses.
- Error bytes 00 or FF (keyboard buffer overrun), in any state: clear all 512 `key_down` bits, go to IDLE, no `key_valid`. `last_change` is held.
- Timeout:
  - In any state other than IDLE, a counter increments each cycle without `rx_valid` and clears on `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`: go to IDLE, no event, `key_down` held.
  - The counter is held at 0 in IDLE.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Only one bit of `key_down` changes per event.

## Timing

- Reset values: `key_down`=0, `last_change`=9'h000, `key_valid`=0, state IDLE, `skip_cnt`=0, timeout counter=0.
- `rst` overrides all other inputs in the same cycle.
- Latency: for a final byte with `rx_valid` high in cycle n, `key_down`, `last_change` and `key_valid`=1 are all visible in cycle n+1. `key_valid` is 0 again in n+2 unless another event completes.
- All outputs are registered; there is no combinational path from input to output.
- `rx_valid` is accepted every cycle; back-to-back bytes are legal and each is parsed in order.
- If `rx_valid` coincides with the cycle the counter would expire, the byte wins: it is parsed in the current state and the counter clears.
- Reset asserted mid-sequence (e.g. after E0): the parser returns to IDLE, and the next byte is parsed as a fresh sequence.

## Test plan

- Reset, then feed bytes 1C, F0, 1C:
  - After 1C: `key_down[0x01C]`=1, `last_change`=0x01C, one `key_valid` pulse one cycle after the strobe.
  - After F0 1C: the bit clears and a second pulse occurs.
- Feed E0 75 then E0 F0 75:
  - `key_down[0x175]` sets then clears.
  - `last_change`=0x175 on both events.
  - `key_down[0x075]` remains 0.
- Press 12 (left shift), then feed 1C three times:
  - Both `key_down[0x012]` and `key_down[0x01C]` are set.
  - Three `key_valid` pulses, all with `last_change`=0x01C.
- Feed E1 14 77 E1 F0 14 F0 77 then 1C:
  - No pulses and no `key_down` change during the pause sequence.
  - 1C then sets bit 0x01C normally.
- Feed E0, wait `TIMEOUT_CYCLES`+2 cycles, then 6B:
  - Parsed as a plain make: `key_down[0x06B]`=1, `key_down[0x16B]`=0.
  - Repeat with 6B arriving exactly at the expiry cycle: the byte is parsed as an extended make, setting bit 0x16B.
- With several keys held, feed FF:
  - `key_down` becomes all zeros with no pulse.
- Separately, assert `rst` after F0: then feed 1C, which is parsed as a make.
